// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: shift-and-add multiply sequencer driving a shared ripple adder
module mul_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     add_a,
  output logic [WIDTH-1:0]     add_b,
  output logic                 add_cin,
  input  logic [WIDTH-1:0]     add_sum,
  input  logic                 add_co
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] mcand, hi, lo;
  logic [CW-1:0] cnt;
  logic accept, last;
  always_comb begin
    accept   = (state != RUN) && start;
    last     = cnt == CW'(WIDTH - 1);
    state_nx = accept ? RUN : (state == RUN) ? (last ? DONE : RUN) : IDLE;
    busy     = state == RUN;
    done     = state == DONE;
    add_a    = busy ? hi : '0;
    add_b    = (busy && lo[0]) ? mcand : '0;
    add_cin  = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mcand   <= '0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        mcand <= op_a;
        lo    <= op_b;
        hi    <= '0;
        cnt   <= '0;
      end else if (state == RUN) begin
        hi  <= {add_co, add_sum[WIDTH-1:1]};
        lo  <= {add_sum[0], lo[WIDTH-1:1]};
        cnt <= cnt + 1'b1;
        // product mirrors the post-update {hi, lo} so it is valid alongside done
        if (last) product <= {add_co, add_sum, lo[WIDTH-1:1]};
      end
    end
  end
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: scoreboard bench for the shift-and-add multiply sequencer
module tb_mul_seq_ctrl;
  logic clk = 0, rst = 1, start = 0;
  logic [15:0] op_a = 0, op_b = 0, add_a, add_b, add_sum;
  logic busy, done, add_cin, add_co;
  logic [31:0] product;
  int vectors = 0, miscompares = 0;
  logic [31:0] sb[$];
  int w_cyc, w_busy, w_cin_bad, w_addb_nz, w_co, w_done;
  bit ok;

  mul_seq_ctrl dut (.clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .product(product), .add_a(add_a), .add_b(add_b),
    .add_cin(add_cin), .add_sum(add_sum), .add_co(add_co));

  assign {add_co, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};

  always #5 clk = ~clk;

  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    op_a = a; op_b = b; start = 1;
    sb.push_back({16'd0, a} * {16'd0, b});
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(input int limit);
    w_cyc = 0; w_busy = 0; w_cin_bad = 0; w_addb_nz = 0; w_co = 0;
    while (done !== 1'b1 && w_cyc < limit) begin
      if (busy) w_busy++;
      if (add_cin !== 1'b0) w_cin_bad++;
      if (busy && add_b !== 16'd0) w_addb_nz++;
      if (busy && add_co) w_co++;
      @(negedge clk);
      w_cyc++;
    end
    ok = done === 1'b1;
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL done_timeout got no done within %0d cycles", limit); end
  endtask

  task automatic check_product(input string name);
    logic [31:0] exp;
    exp = sb.size() ? sb.pop_front() : 32'hxxxxxxxx;
    vectors++;
    if (product !== exp) begin miscompares++; $display("FAIL %s product got %h want %h", name, product, exp); end
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, done, product, add_a, add_b, add_cin} !== 66'd0) begin
      miscompares++; $display("FAIL reset outputs got %h want 0", {busy, done, product, add_a, add_b, add_cin});
    end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    issue(16'd3, 16'd5);
    wait_done(40);
    vectors++;
    if (w_cyc !== 16) begin miscompares++; $display("FAIL basic_latency got %0d want 16", w_cyc); end
    vectors++;
    if (w_busy !== 16) begin miscompares++; $display("FAIL basic_busy_cycles got %0d want 16", w_busy); end
    vectors++;
    if (w_cin_bad !== 0) begin miscompares++; $display("FAIL basic_cin got %0d nonzero cycles want 0", w_cin_bad); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_in_done got %b want 0", busy); end
    check_product("basic");
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL basic_done_pulse got %b want 0", done); end
    vectors++;
    if (product !== 32'h0000000F) begin miscompares++; $display("FAIL basic_hold got %h want 0000000f", product); end
  endtask

  task automatic test_max;
    issue(16'hFFFF, 16'hFFFF);
    wait_done(40);
    vectors++;
    if (w_co === 0) begin miscompares++; $display("FAIL max_carry got %0d carry cycles want >0", w_co); end
    check_product("max");
    @(negedge clk);
  endtask

  task automatic test_carry;
    issue(16'h8000, 16'h0002);
    wait_done(40);
    check_product("carry");
    @(negedge clk);
    issue(16'h1234, 16'h0000);
    wait_done(40);
    vectors++;
    if (w_addb_nz !== 0) begin miscompares++; $display("FAIL zero_addb got %0d nonzero cycles want 0", w_addb_nz); end
    check_product("zero");
    @(negedge clk);
  endtask

  task automatic test_ignore;
    issue(16'd7, 16'd9);
    repeat (4) @(negedge clk);
    op_a = 1; op_b = 1; start = 1;
    @(negedge clk);
    start = 0;
    wait_done(40);
    check_product("ignore");
    w_done = 0;
    repeat (25) begin @(negedge clk); if (done || busy) w_done++; end
    vectors++;
    if (w_done !== 0) begin miscompares++; $display("FAIL ignore_extra_op got %0d active cycles want 0", w_done); end
  endtask

  task automatic test_mid_reset;
    op_a = 16'hFFFF; op_b = 16'd2; start = 1;
    @(negedge clk);
    start = 0;
    repeat (7) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    vectors++;
    if ({busy, done, product, add_a, add_b} !== 65'd0) begin
      miscompares++; $display("FAIL midreset outputs got %h want 0", {busy, done, product, add_a, add_b});
    end
    w_done = 0;
    repeat (20) begin @(negedge clk); if (done) w_done++; end
    vectors++;
    if (w_done !== 0) begin miscompares++; $display("FAIL midreset_done got %0d pulses want 0", w_done); end
    issue(16'd6, 16'd7);
    wait_done(40);
    check_product("after_reset");
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    op_a = 16'd10; op_b = 16'd10; start = 1;
    sb.push_back(32'd100);
    @(negedge clk);
    wait_done(40);
    check_product("b2b_first");
    op_a = 16'h00FF; op_b = 16'h0100;
    sb.push_back(32'h0000FF00);
    @(negedge clk);
    start = 0;
    vectors++;
    if ({busy, done} !== 2'b10) begin miscompares++; $display("FAIL b2b_busy got %b want 10", {busy, done}); end
    vectors++;
    if (product !== 32'd100) begin miscompares++; $display("FAIL b2b_hold got %h want 00000064", product); end
    wait_done(40);
    vectors++;
    if (w_cyc + 1 !== 17) begin miscompares++; $display("FAIL b2b_spacing got %0d want 17", w_cyc + 1); end
    check_product("b2b_second");
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_max;
    test_carry;
    test_ignore;
    test_mid_reset;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
